bpsk_frame_scheduler: RTL and testbench

Sequences received bytes through the Hamming encoder and BPSK modulator path. Bytes from the UART receiver (data plus dv strobe) are buffered in a small FIFO and presented to the encoder one at a time. After the encoder settles, the scheduler gates the modulator enable for exactly one 12-bit codeword duration, then signals completion. It sits between uart_rx and hamming_encoder/bpsk_modulator and replaces the free-running external modulator enable.

---
 rtl/bpsk_frame_scheduler_if.sv | 44 ++++
 rtl/bpsk_frame_scheduler.sv | 166 ++++++++++++++++
 tb/tb_bpsk_frame_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpsk_frame_scheduler_if.sv
// Bundle between the byte receiver / transmit path and bpsk_frame_scheduler.
//
// Handshake semantics: rx_dv is a one-cycle push strobe with no back-pressure.
// A byte is offered on every cycle rx_dv is high and is either stored or dropped
// (dropped bytes raise the sticky overflow flag). There is no ready signal.
// Downstream, mod_en and frame_done are framing outputs, not a handshake.
//
// Signals:
//   rx_data/rx_dv  : byte from receiver and its write strobe
//   enable         : allow new frames to start
//   clr_ovf        : clear sticky overflow
//   enc_data       : byte presented to the encoder for the current frame
//   mod_en         : modulator enable, high for exactly one codeword per byte
//   busy           : scheduler is not idle
//   frame_done     : one-cycle pulse when a byte finishes
//   overflow       : sticky dropped-byte flag
//   fifo_count     : buffer occupancy 0..FIFO_DEPTH
//   fsm_state      : current scheduler state, for observation
interface bpsk_frame_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_WIDTH-1:0]       rx_data;
  logic                        rx_dv;
  logic                        enable;
  logic                        clr_ovf;
  logic [DATA_WIDTH-1:0]       enc_data;
  logic                        mod_en;
  logic                        busy;
  logic                        frame_done;
  logic                        overflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [2:0]                  fsm_state;

  modport master (
    output rx_data, rx_dv, enable, clr_ovf,
    input  enc_data, mod_en, busy, frame_done, overflow, fifo_count, fsm_state
  );

  modport slave (
    input  rx_data, rx_dv, enable, clr_ovf,
    output enc_data, mod_en, busy, frame_done, overflow, fifo_count, fsm_state
  );
endinterface

// File: rtl/bpsk_frame_scheduler.sv
// Byte scheduler for the Hamming encoder / BPSK modulator path.
// Received bytes are buffered in a small FIFO; each byte is loaded into
// enc_data, given GUARD_CYCLES for the encoder to settle, and then mod_en is
// held high for exactly CODE_WIDTH*SAMPLE_NUMBER cycles (one codeword).
// frame_done pulses for one cycle at the end of every byte.
//
// Ports:
//   clk  : system clock
//   arst : asynchronous reset, active-high
//   bus  : bpsk_frame_scheduler_if slave modport (see interface header)
//
// State encoding on fsm_state: 0 IDLE, 1 LOAD, 2 SETTLE, 3 SEND, 4 DONE.
module bpsk_frame_scheduler #(
  parameter int DATA_WIDTH    = 8,
  parameter int CODE_WIDTH    = 12,
  parameter int SAMPLE_NUMBER = 256,
  parameter int FIFO_DEPTH    = 4,
  parameter int GUARD_CYCLES  = 2
) (
  input logic                   clk,
  input logic                   arst,
  bpsk_frame_scheduler_if.slave bus
);

  localparam int FRAME_CYCLES = CODE_WIDTH * SAMPLE_NUMBER;
  localparam int CW           = $clog2(FRAME_CYCLES);
  localparam int PW           = $clog2(FIFO_DEPTH);
  localparam int NW           = PW + 1;

  localparam logic [NW-1:0] DEPTH_N    = NW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_GUARD = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] LAST_SEND  = CW'(FRAME_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SEND   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [NW-1:0]         count;
  logic [DATA_WIDTH-1:0] enc_data;
  logic                  mod_en;
  logic                  frame_done;
  logic                  overflow;

  logic pop;
  logic push;
  logic drop;
  logic has_data;

  // LOAD is only ever entered with count>0 and nothing else removes entries,
  // so the pop never underflows. A pop frees a slot in the same edge, which is
  // why a write into a full FIFO during LOAD is still accepted.
  assign pop      = (state == LOAD);
  assign push     = bus.rx_dv && ((count != DEPTH_N) || pop);
  assign drop     = bus.rx_dv && !push;
  assign has_data = (count != '0);

  // Storage: when full and popping, wr_ptr equals rd_ptr; the head is read in
  // LOAD from the old contents before this edge overwrites the slot.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      cnt        <= '0;
      enc_data   <= '0;
      mod_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable && has_data) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          enc_data <= mem[rd_ptr];
          cnt      <= '0;
          state    <= SETTLE;
        end
        SETTLE: begin
          if (cnt == LAST_GUARD) begin
            cnt    <= '0;
            mod_en <= 1'b1;
            state  <= SEND;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SEND: begin
          if (cnt == LAST_SEND) begin
            cnt        <= '0;
            mod_en     <= 1'b0;
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          // Chaining straight into LOAD keeps back-to-back bytes gap-free.
          if (bus.enable && has_data) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          mod_en     <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enc_data   = enc_data;
  assign bus.mod_en     = mod_en;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = frame_done;
  assign bus.overflow   = overflow;
  assign bus.fifo_count = count;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_bpsk_frame_scheduler.sv
// Bench for bpsk_frame_scheduler with a short codeword (SAMPLE_NUMBER=4) so a
// frame is 48 modulator cycles and a byte occupies 52 cycles in total.
// Inputs are driven on the falling clock edge; outputs are sampled there too.
module tb_bpsk_frame_scheduler;

  localparam int DW     = 8;
  localparam int CWID   = 12;
  localparam int SN     = 4;
  localparam int FD     = 4;
  localparam int GC     = 2;
  localparam int FRAME  = CWID * SN;
  localparam int PERIOD = 2 + GC + FRAME;

  logic clk = 1'b0;
  logic arst;

  always #5 clk = ~clk;

  bpsk_frame_scheduler_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  bpsk_frame_scheduler #(
    .DATA_WIDTH(DW), .CODE_WIDTH(CWID), .SAMPLE_NUMBER(SN),
    .FIFO_DEPTH(FD), .GUARD_CYCLES(GC)
  ) u_dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] stim[8];

  // ---------------- monitor / scoreboard ----------------
  int   run_len    = 0;
  logic prev_mod   = 1'b0;
  int   fd_total   = 0;
  int   peak_count = 0;

  always @(negedge clk) begin
    if (arst) begin
      run_len  = 0;
      prev_mod = 1'b0;
    end else begin
      if (int'(bus.fifo_count) > peak_count) peak_count = int'(bus.fifo_count);
      if (bus.frame_done) fd_total++;
      if (bus.mod_en && !prev_mod) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL frame_byte: got unexpected frame with enc_data %0h, required none", bus.enc_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (bus.enc_data !== e) begin
            tests_failed++;
            $display("FAIL frame_byte: got %0h required %0h", bus.enc_data, e);
          end
        end
      end
      if (bus.mod_en) begin
        run_len++;
      end else if (prev_mod) begin
        tests_run++;
        if (run_len !== FRAME) begin
          tests_failed++;
          $display("FAIL mod_en_length: got %0d required %0d", run_len, FRAME);
        end
        run_len = 0;
      end
      prev_mod = bus.mod_en;
    end
  end

  // ---------------- driver tasks ----------------
  // Each task starts and ends just after a falling edge.
  task automatic drive_stim(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx_data = stim[i];
      bus.rx_dv   = 1'b1;
      @(negedge clk);
    end
    bus.rx_dv = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (bus.busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: busy still %0b after %0d cycles, required 0", name, bus.busy, budget);
    end
  endtask

  task automatic wait_mod_en(input int budget, input string name);
    int k;
    k = 0;
    while (!bus.mod_en && k < budget) begin
      @(negedge clk);
      k++;
    end
    tests_run++;
    if (bus.mod_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: mod_en got %0b after %0d cycles, required 1", name, bus.mod_en, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic active;
    arst        = 1'b1;
    bus.rx_data = '0;
    bus.rx_dv   = 1'b0;
    bus.enable  = 1'b0;
    bus.clr_ovf = 1'b0;
    #2;
    tests_run += 6;
    if (bus.enc_data   !== 8'h00) begin tests_failed++; $display("FAIL reset_enc_data: got %0h required 0", bus.enc_data); end
    if (bus.mod_en     !== 1'b0)  begin tests_failed++; $display("FAIL reset_mod_en: got %0b required 0", bus.mod_en); end
    if (bus.busy       !== 1'b0)  begin tests_failed++; $display("FAIL reset_busy: got %0b required 0", bus.busy); end
    if (bus.frame_done !== 1'b0)  begin tests_failed++; $display("FAIL reset_frame_done: got %0b required 0", bus.frame_done); end
    if (bus.overflow   !== 1'b0)  begin tests_failed++; $display("FAIL reset_overflow: got %0b required 0", bus.overflow); end
    if (bus.fifo_count !== '0)    begin tests_failed++; $display("FAIL reset_fifo_count: got %0d required 0", bus.fifo_count); end
    repeat (3) @(negedge clk);
    #2 arst = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
    active = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy || bus.mod_en) active = 1'b1;
    end
    tests_run++;
    if (active !== 1'b0) begin tests_failed++; $display("FAIL idle_quiet: busy/mod_en seen %0b required 0", active); end
  endtask

  task automatic test_single_byte();
    int first_busy, first_enc, first_mod, mod_cnt, fd_at, fd_cnt, busy_fall;
    logic prev_busy;
    first_busy = -1; first_enc = -1; first_mod = -1; mod_cnt = 0;
    fd_at = -1; fd_cnt = 0; busy_fall = -1;
    bus.enable = 1'b1;
    stim[0] = 8'hA5;
    exp_q.push_back(8'hA5);
    drive_stim(1);
    tests_run++;
    if (bus.fifo_count !== 3'd1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_written: count %0d busy %0b required 1 and 0", bus.fifo_count, bus.busy);
    end
    prev_busy = bus.busy;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.busy && first_busy < 0) first_busy = k;
      if (bus.enc_data === 8'hA5 && first_enc < 0) first_enc = k;
      if (bus.mod_en) begin
        if (first_mod < 0) first_mod = k;
        mod_cnt++;
      end
      if (bus.frame_done) begin fd_cnt++; fd_at = k; end
      if (!bus.busy && prev_busy && busy_fall < 0) busy_fall = k;
      prev_busy = bus.busy;
    end
    tests_run += 7;
    if (first_busy !== 1)     begin tests_failed++; $display("FAIL single_load_cycle: got %0d required 1", first_busy); end
    if (first_enc  !== 2)     begin tests_failed++; $display("FAIL single_enc_cycle: got %0d required 2", first_enc); end
    if (first_mod  !== 4)     begin tests_failed++; $display("FAIL single_mod_start: got %0d required 4", first_mod); end
    if (mod_cnt    !== FRAME) begin tests_failed++; $display("FAIL single_mod_count: got %0d required %0d", mod_cnt, FRAME); end
    if (fd_at      !== 52)    begin tests_failed++; $display("FAIL single_done_cycle: got %0d required 52", fd_at); end
    if (fd_cnt     !== 1)     begin tests_failed++; $display("FAIL single_done_count: got %0d required 1", fd_cnt); end
    if (busy_fall  !== 53)    begin tests_failed++; $display("FAIL single_busy_fall: got %0d required 53", busy_fall); end
  endtask

  task automatic test_back_to_back();
    int fd_t[3];
    int nfd, gaps, low_len, k;
    logic seen_high;
    int gap_len[4];
    nfd = 0; gaps = 0; low_len = 0; seen_high = 1'b0; k = 0;
    peak_count = 0;
    bus.enable = 1'b1;
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    drive_stim(3);
    while (nfd < 3 && k < 250) begin
      @(negedge clk);
      k++;
      if (bus.mod_en) begin
        if (seen_high && low_len > 0 && gaps < 4) begin gap_len[gaps] = low_len; gaps++; end
        seen_high = 1'b1;
        low_len = 0;
      end else if (seen_high) begin
        low_len++;
      end
      if (bus.frame_done) begin fd_t[nfd] = k; nfd++; end
    end
    tests_run += 2;
    // The first pop overlaps the third write, so occupancy tops out at 2.
    if (peak_count !== 2) begin tests_failed++; $display("FAIL b2b_peak_count: got %0d required 2", peak_count); end
    if (nfd !== 3)        begin tests_failed++; $display("FAIL b2b_done_count: got %0d required 3", nfd); end
    if (nfd == 3) begin
      tests_run += 2;
      if (fd_t[1] - fd_t[0] !== PERIOD) begin tests_failed++; $display("FAIL b2b_spacing1: got %0d required %0d", fd_t[1] - fd_t[0], PERIOD); end
      if (fd_t[2] - fd_t[1] !== PERIOD) begin tests_failed++; $display("FAIL b2b_spacing2: got %0d required %0d", fd_t[2] - fd_t[1], PERIOD); end
    end
    tests_run++;
    if (gaps !== 2) begin tests_failed++; $display("FAIL b2b_gap_count: got %0d required 2", gaps); end
    for (int i = 0; i < gaps; i++) begin
      tests_run++;
      if (gap_len[i] !== 2 + GC) begin tests_failed++; $display("FAIL b2b_gap_len: got %0d required %0d", gap_len[i], 2 + GC); end
    end
    wait_idle(10, "b2b_idle");
  endtask

  task automatic test_overflow();
    int fd0;
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) stim[i] = DW'(8'h40 + i);
    for (int i = 0; i < 4; i++) exp_q.push_back(stim[i]);
    drive_stim(5);
    tests_run += 3;
    if (bus.fifo_count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count: got %0d required 4", bus.fifo_count); end
    if (bus.overflow !== 1'b1)   begin tests_failed++; $display("FAIL ovf_flag: got %0b required 1", bus.overflow); end
    if (bus.busy !== 1'b0)       begin tests_failed++; $display("FAIL ovf_held_idle: got busy %0b required 0", bus.busy); end
    fd0 = fd_total;
    bus.enable = 1'b1;
    @(negedge clk);
    wait_idle(4 * PERIOD + 20, "ovf_drain");
    repeat (60) @(negedge clk);
    tests_run += 4;
    if (fd_total - fd0 !== 4)  begin tests_failed++; $display("FAIL ovf_frames: got %0d required 4", fd_total - fd0); end
    if (exp_q.size() !== 0)    begin tests_failed++; $display("FAIL ovf_queue_left: got %0d required 0", exp_q.size()); end
    if (bus.overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %0b required 1", bus.overflow); end
    if (bus.busy !== 1'b0)     begin tests_failed++; $display("FAIL ovf_no_extra: got busy %0b required 0", bus.busy); end
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    tests_run++;
    if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %0b required 0", bus.overflow); end
  endtask

  task automatic test_full_pop();
    int fd0, k;
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stim[i] = DW'(8'h50 + i);
      exp_q.push_back(stim[i]);
    end
    drive_stim(4);
    // Drop and clear in the same cycle: the flag must end up set.
    bus.rx_data = 8'h54; bus.rx_dv = 1'b1; bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.rx_dv = 1'b0; bus.clr_ovf = 1'b0;
    tests_run += 2;
    if (bus.overflow !== 1'b1)   begin tests_failed++; $display("FAIL set_beats_clear: got %0b required 1", bus.overflow); end
    if (bus.fifo_count !== 3'd4) begin tests_failed++; $display("FAIL drop_count: got %0d required 4", bus.fifo_count); end
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    tests_run++;
    if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL clear_again: got %0b required 0", bus.overflow); end
    fd0 = fd_total;
    bus.enable = 1'b1;
    k = 0;
    while (!bus.busy && k < 5) begin @(negedge clk); k++; end
    // Now in LOAD: this write lands on the same edge as the pop.
    bus.rx_data = 8'h55; bus.rx_dv = 1'b1;
    exp_q.push_back(8'h55);
    @(negedge clk);
    bus.rx_dv = 1'b0;
    tests_run += 2;
    if (bus.fifo_count !== 3'd4) begin tests_failed++; $display("FAIL pop_write_count: got %0d required 4", bus.fifo_count); end
    if (bus.overflow !== 1'b0)   begin tests_failed++; $display("FAIL pop_write_ovf: got %0b required 0", bus.overflow); end
    wait_idle(5 * PERIOD + 20, "pop_write_drain");
    tests_run += 2;
    if (fd_total - fd0 !== 5) begin tests_failed++; $display("FAIL pop_write_frames: got %0d required 5", fd_total - fd0); end
    if (exp_q.size() !== 0)   begin tests_failed++; $display("FAIL pop_write_queue: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_enable_drop();
    int fd0;
    fd0 = fd_total;
    bus.enable = 1'b1;
    stim[0] = 8'h60; stim[1] = 8'h61;
    exp_q.push_back(8'h60);
    drive_stim(2);
    wait_mod_en(10, "drop_start");
    bus.enable = 1'b0;
    wait_idle(PERIOD + 10, "drop_finish");
    repeat (10) @(negedge clk);
    tests_run += 4;
    if (fd_total - fd0 !== 1)    begin tests_failed++; $display("FAIL drop_frames: got %0d required 1", fd_total - fd0); end
    if (bus.fifo_count !== 3'd1) begin tests_failed++; $display("FAIL drop_count: got %0d required 1", bus.fifo_count); end
    if (bus.enc_data !== 8'h60)  begin tests_failed++; $display("FAIL drop_enc_hold: got %0h required 60", bus.enc_data); end
    if (bus.busy !== 1'b0)       begin tests_failed++; $display("FAIL drop_stays_idle: got %0b required 0", bus.busy); end
    exp_q.push_back(8'h61);
    bus.enable = 1'b1;
    @(negedge clk);
    wait_idle(PERIOD + 10, "drop_resume");
    tests_run++;
    if (fd_total - fd0 !== 2) begin tests_failed++; $display("FAIL drop_resume_frames: got %0d required 2", fd_total - fd0); end
  endtask

  task automatic test_reset_mid_send();
    logic active;
    bus.enable = 1'b1;
    stim[0] = 8'h70; stim[1] = 8'h71;
    exp_q.push_back(8'h70);
    drive_stim(2);
    wait_mod_en(10, "rst_reach_send");
    bus.enable = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus.fifo_count !== 3'd1) begin tests_failed++; $display("FAIL rst_pre_count: got %0d required 1", bus.fifo_count); end
    #2 arst = 1'b1;
    #1;
    tests_run += 3;
    if (bus.mod_en !== 1'b0)   begin tests_failed++; $display("FAIL rst_async_mod_en: got %0b required 0", bus.mod_en); end
    if (bus.busy !== 1'b0)     begin tests_failed++; $display("FAIL rst_async_busy: got %0b required 0", bus.busy); end
    if (bus.fifo_count !== '0) begin tests_failed++; $display("FAIL rst_async_count: got %0d required 0", bus.fifo_count); end
    @(negedge clk);
    #2 arst = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
    active = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy || bus.mod_en) active = 1'b1;
    end
    tests_run += 2;
    if (active !== 1'b0)    begin tests_failed++; $display("FAIL rst_stays_idle: got %0b required 0", active); end
    if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL rst_queue: got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_enable_drop();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
